// File: rtl/evo_timebase_pkg.sv
// Shared types and constants for the Evo timebase: timer FSM states, the
// microseconds-per-millisecond ratio and the timer tick source encoding.
package evo_timebase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } tmr_state_e;

    localparam int unsigned US_PER_MS = 1000;

    localparam logic SRC_1MHZ  = 1'b0;
    localparam logic SRC_16MHZ = 1'b1;

endpackage

// File: rtl/evo_strobe_div.sv
// Modulo-N strobe divider: en_out is high combinationally on the en_in that
// wraps the internal count from N-1 back to 0.
module evo_strobe_div #(
    parameter int unsigned N = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_in,
    output logic en_out
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_top;

    assign at_top = (cnt_q == CW'(N - 1));
    assign en_out = en_in && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (en_in) begin
            cnt_d = at_top ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/evo_timebase.sv
// Evo timebase: free-running us/ms counters, 1 kHz strobe and a start/stop
// countdown timer. Define EVO_TIMEBASE_WDOG_EN to build the en1mhz-loss watchdog.
module evo_timebase
    import evo_timebase_pkg::*;
#(
    parameter int unsigned TMR_WIDTH  = 24,
    parameter int unsigned WDOG_LIMIT = 240
) (
    input  logic                 clk_bsp,
    input  logic                 reset,
    input  logic                 en1mhz,
    input  logic                 en16mhz,
    input  logic                 tmr_src,
    input  logic                 tmr_mode,
    input  logic [TMR_WIDTH-1:0] tmr_period,
    input  logic                 tmr_start,
    input  logic                 tmr_stop,
    output logic                 tmr_busy,
    output logic                 tmr_expire,
    output logic [TMR_WIDTH-1:0] tmr_count,
    output logic [31:0]          us_count,
    output logic [31:0]          ms_count,
    output logic                 en1khz,
    input  logic                 wdog_clr,
    output logic                 wdog_fault
);

    logic        ms_wrap;
    logic [31:0] us_count_q, us_count_d;
    logic [31:0] ms_count_q, ms_count_d;
    logic        en1khz_q, en1khz_d;

    evo_strobe_div #(.N(US_PER_MS)) u_ms_div (
        .clk    (clk_bsp),
        .rst    (reset),
        .en_in  (en1mhz),
        .en_out (ms_wrap)
    );

    always_comb begin
        us_count_d = en1mhz  ? us_count_q + 32'd1 : us_count_q;
        ms_count_d = ms_wrap ? ms_count_q + 32'd1 : ms_count_q;
        en1khz_d   = ms_wrap;
    end

    always_ff @(posedge clk_bsp or posedge reset) begin
        if (reset) begin
            us_count_q <= '0;
            ms_count_q <= '0;
            en1khz_q   <= 1'b0;
        end else begin
            us_count_q <= us_count_d;
            ms_count_q <= ms_count_d;
            en1khz_q   <= en1khz_d;
        end
    end

    assign us_count = us_count_q;
    assign ms_count = ms_count_q;
    assign en1khz   = en1khz_q;

    tmr_state_e           state_q, state_d;
    logic [TMR_WIDTH-1:0] count_q, count_d;
    logic [TMR_WIDTH-1:0] period_q, period_d;
    logic                 mode_q, mode_d;
    logic                 expire_q, expire_d;
    logic                 busy_q, busy_d;
    logic                 tick;

    assign tick = (tmr_src == SRC_16MHZ) ? en16mhz : en1mhz;

    // Stop has priority over start and over a coincident tick in every state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tmr_start && !tmr_stop && (tmr_period != '0)) begin
                    state_d  = ST_RUN;
                    count_d  = tmr_period;
                    period_d = tmr_period;
                    mode_d   = tmr_mode;
                end
            end
            ST_RUN: begin
                if (tmr_stop) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (count_q == TMR_WIDTH'(1)) begin
                        expire_d = 1'b1;
                        if (mode_q) begin
                            count_d = period_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        count_d = count_q - TMR_WIDTH'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (tmr_stop) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (tmr_start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_bsp or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            busy_q   <= busy_d;
        end
    end

    assign tmr_busy   = busy_q;
    assign tmr_expire = expire_q;
    assign tmr_count  = count_q;

`ifdef EVO_TIMEBASE_WDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_LIMIT + 1);

    logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic           wdog_fault_q, wdog_fault_d;
    logic           wdog_hit;

    assign wdog_hit = (wdog_cnt_q == WDW'(WDOG_LIMIT));

    // Setting the fault outranks a simultaneous clear.
    always_comb begin
        wdog_cnt_d   = en1mhz ? '0 : (wdog_hit ? wdog_cnt_q : wdog_cnt_q + WDW'(1));
        wdog_fault_d = wdog_hit ? 1'b1 : (wdog_clr ? 1'b0 : wdog_fault_q);
    end

    always_ff @(posedge clk_bsp or posedge reset) begin
        if (reset) begin
            wdog_cnt_q   <= '0;
            wdog_fault_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fault_q <= wdog_fault_d;
        end
    end

    assign wdog_fault = wdog_fault_q;
`else
    logic wdog_unused;
    assign wdog_unused = wdog_clr | (WDOG_LIMIT == 0);
    assign wdog_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_evo_timebase.sv
// Directed bench for evo_timebase with an expiry scoreboard keyed on clock edge index.
module tb_evo_timebase;

    localparam int TW = 24;

    logic          clk_bsp = 1'b0;
    logic          reset;
    logic          en1mhz, en16mhz, tmr_src, tmr_mode, tmr_start, tmr_stop, wdog_clr;
    logic [TW-1:0] tmr_period;
    logic          tmr_busy, tmr_expire, en1khz, wdog_fault;
    logic [TW-1:0] tmr_count;
    logic [31:0]   us_count, ms_count;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int khz_n  = 0;
    int exp_q[$];

    evo_timebase #(.TMR_WIDTH(TW), .WDOG_LIMIT(240)) dut (
        .clk_bsp    (clk_bsp),
        .reset      (reset),
        .en1mhz     (en1mhz),
        .en16mhz    (en16mhz),
        .tmr_src    (tmr_src),
        .tmr_mode   (tmr_mode),
        .tmr_period (tmr_period),
        .tmr_start  (tmr_start),
        .tmr_stop   (tmr_stop),
        .tmr_busy   (tmr_busy),
        .tmr_expire (tmr_expire),
        .tmr_count  (tmr_count),
        .us_count   (us_count),
        .ms_count   (ms_count),
        .en1khz     (en1khz),
        .wdog_clr   (wdog_clr),
        .wdog_fault (wdog_fault)
    );

    always #5 clk_bsp = ~clk_bsp;

    always @(posedge clk_bsp) edges++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every expiry pulse must match the next scheduled edge index.
    always @(negedge clk_bsp) begin
        if (en1khz === 1'b1) khz_n++;
        if (tmr_expire !== 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_expire", {31'd0, tmr_expire}, 32'd0);
            else                   chk("expire_edge", edges, exp_q.pop_front());
        end
    end

    // One clock cycle with the given strobes/requests; returns at the next negedge.
    task automatic cyc(input logic e1, input logic e16, input logic st, input logic sp);
        en1mhz = e1; en16mhz = e16; tmr_start = st; tmr_stop = sp;
        @(negedge clk_bsp);
        en1mhz = 1'b0; en16mhz = 1'b0; tmr_start = 1'b0; tmr_stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en1mhz = 0; en16mhz = 0; tmr_src = 0; tmr_mode = 0;
        tmr_start = 0; tmr_stop = 0; wdog_clr = 0; tmr_period = '0;
        @(negedge clk_bsp);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        chk("rst_busy", {31'd0, tmr_busy}, 0);
        chk("rst_expire", {31'd0, tmr_expire}, 0);
        chk("rst_count", tmr_count, 0);
        chk("rst_us", us_count, 0);
        chk("rst_ms", ms_count, 0);
        chk("rst_khz", {31'd0, en1khz}, 0);
        chk("rst_wdog", {31'd0, wdog_fault}, 0);
        reset = 1'b0;

        // Free-running counters and the 1 kHz boundary
        repeat (999) cyc(1, 0, 0, 0);
        chk("ms_before_wrap", ms_count, 0);
        chk("us_999", us_count, 999);
        cyc(1, 0, 0, 0);
        chk("ms_at_wrap", ms_count, 1);
        chk("khz_at_wrap", {31'd0, en1khz}, 1);
        repeat (1500) cyc(1, 0, 0, 0);
        chk("us_2500", us_count, 2500);
        chk("ms_2500", ms_count, 2);
        chk("khz_pulses", khz_n, 2);

        // Zero period is ignored
        tmr_period = 0;
        cyc(0, 0, 1, 0);
        chk("zero_period_busy", {31'd0, tmr_busy}, 0);

        // One-shot, 1 MHz source, period 5
        tmr_src = 0; tmr_mode = 0; tmr_period = 5;
        cyc(0, 0, 1, 0);
        chk("os_busy", {31'd0, tmr_busy}, 1);
        chk("os_load", tmr_count, 5);
        cyc(0, 1, 0, 0);
        chk("os_src_ignore", tmr_count, 5);
        repeat (4) cyc(1, 0, 0, 0);
        chk("os_count1", tmr_count, 1);
        exp_q.push_back(edges + 1);
        cyc(1, 0, 0, 0);
        chk("os_expire", {31'd0, tmr_expire}, 1);
        chk("os_busy_low", {31'd0, tmr_busy}, 0);
        chk("os_count0", tmr_count, 0);
        cyc(1, 0, 0, 0);
        chk("os_single_pulse", {31'd0, tmr_expire}, 0);

        // Periodic, 16 MHz source, period 3; a period change mid-run is ignored
        tmr_src = 1; tmr_mode = 1; tmr_period = 3;
        cyc(0, 0, 1, 0);
        tmr_period = 7;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) exp_q.push_back(edges + 1);
            cyc(0, 1, 0, 0);
            if (i % 3 == 2) chk("per_reload", tmr_count, 3);
        end
        chk("per_busy", {31'd0, tmr_busy}, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("per_idle_busy", {31'd0, tmr_busy}, 0);
        chk("per_idle_count", tmr_count, 0);

        // Pause/resume, period 4
        tmr_src = 0; tmr_mode = 0; tmr_period = 4;
        cyc(0, 0, 1, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("pause_busy", {31'd0, tmr_busy}, 1);
        repeat (10) cyc(1, 0, 0, 0);
        chk("pause_hold", tmr_count, 2);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("resume_count", tmr_count, 1);
        exp_q.push_back(edges + 1);
        cyc(1, 0, 0, 0);
        chk("resume_expire", {31'd0, tmr_expire}, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("stop2_busy", {31'd0, tmr_busy}, 0);
        chk("stop2_count", tmr_count, 0);

        // Start+stop together in RUN pauses; stop with the final tick suppresses expiry
        cyc(0, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("startstop_busy", {31'd0, tmr_busy}, 1);
        repeat (3) cyc(1, 0, 0, 0);
        chk("startstop_hold", tmr_count, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("tickstop_no_expire", {31'd0, tmr_expire}, 0);
        chk("tickstop_count", tmr_count, 1);
        cyc(0, 0, 0, 1);
        chk("tickstop_idle", {31'd0, tmr_busy}, 0);

        // Asynchronous reset aborts a running timer between clock edges
        cyc(0, 0, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", {31'd0, tmr_busy}, 0);
        chk("async_count", tmr_count, 0);
        chk("async_us", us_count, 0);
        @(negedge clk_bsp);
        reset = 1'b0;

        // Watchdog on 1 MHz strobe loss
        repeat (3) cyc(1, 0, 0, 0);
        chk("wdog_clear_start", {31'd0, wdog_fault}, 0);
        repeat (240) cyc(0, 0, 0, 0);
        chk("wdog_240", {31'd0, wdog_fault}, 0);
        cyc(0, 0, 0, 0);
`ifdef EVO_TIMEBASE_WDOG_EN
        chk("wdog_241", {31'd0, wdog_fault}, 1);
`else
        chk("wdog_241", {31'd0, wdog_fault}, 0);
`endif
        cyc(1, 0, 0, 0);
        wdog_clr = 1'b1;
        cyc(1, 0, 0, 0);
        wdog_clr = 1'b0;
        chk("wdog_cleared", {31'd0, wdog_fault}, 0);

        cyc(0, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
